// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types and constants for the keycode event controller.
//   - HID keycodes for the keys the game cares about
//   - event type encoding and the packed {type, code} queue entry
//   - controller FSM state encoding
//   - WASD decode helper
package keycode_pkg;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_ENTER = 8'h28;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_t;

    // 10-bit queue entry: {type[1:0], code[7:0]}
    typedef struct packed {
        evt_type_t  etype;
        logic [7:0] code;
    } evt_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_HELD       = 2'b01,
        ST_EMIT_PRESS = 2'b10
    } kc_state_t;

    // {W,A,S,D} level for a held keycode; anything else is no direction.
    function automatic logic [3:0] wasd_decode(input logic [7:0] code);
        logic [3:0] dir;
        dir = '0;
        case (code)
            KC_W:    dir = 4'b1000;
            KC_A:    dir = 4'b0100;
            KC_S:    dir = 4'b0010;
            KC_D:    dir = 4'b0001;
            default: dir = '0;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// keycode_evt_fifo: synchronous first-word-fall-through FIFO.
//   clk_i      clock
//   rst_i      synchronous active-high reset (empties the queue)
//   wr_en_i    write request
//   wr_data_i  entry to write
//   rd_en_i    pop request (ignored while empty)
//   rd_data_o  head entry (valid while !empty_o)
//   full_o     DEPTH entries held
//   empty_o    no entries held
//   count_o    number of entries held
//   wr_drop_o  write request refused because full with no same-cycle pop
// DEPTH must be a power of two (pointers wrap naturally), >= 2.
module keycode_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wr_drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so a full queue still takes a write then.
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign wr_drop_o = wr_en_i && full_o && !do_rd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/keycode_event_ctrl.sv
// keycode_event_ctrl: keycode glitch filter, held-key tracker and event queue.
//   clk_clk      system clock
//   reset_reset  synchronous active-high reset
//   keycode      raw HID keycode, 0x00 = no key
//   evt_valid    head event available
//   evt_ready    consumer pops head when evt_valid && evt_ready
//   evt_type     head type: 01 PRESS, 10 RELEASE, 11 REPEAT (00 when empty)
//   evt_code     head keycode (00 when empty)
//   held_code    filtered, accepted keycode
//   dir_held     {W,A,S,D} levels decoded from held_code
//   fifo_count   queued entries
//   overflow     sticky: an event was dropped on a full queue
// Build option: define KEYCODE_REPEAT_EN to generate auto-repeat (REPEAT) events.
module keycode_event_ctrl
    import keycode_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY  = 20,
    parameter int unsigned REPEAT_PERIOD = 8,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [7:0]                    keycode,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [1:0]                    evt_type,
    output logic [7:0]                    evt_code,
    output logic [7:0]                    held_code,
    output logic [3:0]                    dir_held,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

    logic [7:0]    cand_q;
    logic [SW-1:0] stab_cnt_q;
    logic [7:0]    held_q;
    logic          ovf_q;
    kc_state_t     state_q, state_d;
    logic          accept;
    logic          rpt_fire;
    logic          wr_en;
    evt_t          wr_evt;
    evt_t          head;
    logic [9:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_drop;

    // Candidate has been stable long enough and differs from the held key.
    assign accept = (stab_cnt_q == SW'(STABLE_CYCLES)) && (cand_q != held_q);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cand_q     <= '0;
            stab_cnt_q <= '0;
            held_q     <= '0;
        end else begin
            if (keycode != cand_q) begin
                cand_q     <= keycode;
                stab_cnt_q <= SW'(1);
            end else if (stab_cnt_q != SW'(STABLE_CYCLES)) begin
                stab_cnt_q <= stab_cnt_q + 1'b1;
            end
            if (accept) held_q <= cand_q;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Key-to-key change writes RELEASE(old) now and defers PRESS(new) one
    // cycle via EMIT_PRESS, keeping at most one queue write per cycle.
    always_comb begin
        state_d      = state_q;
        wr_en        = 1'b0;
        wr_evt.etype = EVT_PRESS;
        wr_evt.code  = '0;
        case (state_q)
            ST_IDLE, ST_HELD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (held_q == KC_NONE) begin
                        wr_evt.etype = EVT_PRESS;
                        wr_evt.code  = cand_q;
                        state_d      = ST_HELD;
                    end else begin
                        wr_evt.etype = EVT_RELEASE;
                        wr_evt.code  = held_q;
                        state_d      = (cand_q == KC_NONE) ? ST_IDLE : ST_EMIT_PRESS;
                    end
                end else if (rpt_fire) begin
                    wr_en        = 1'b1;
                    wr_evt.etype = EVT_REPEAT;
                    wr_evt.code  = held_q;
                end
            end
            ST_EMIT_PRESS: begin
                wr_en        = 1'b1;
                wr_evt.etype = EVT_PRESS;
                wr_evt.code  = held_q;
                state_d      = ST_HELD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef KEYCODE_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_seen_q, rpt_seen_d;
    logic [RW-1:0] rpt_inc;
    logic [RW-1:0] rpt_limit;

    // PRESS is only ever written outside HELD, so clearing whenever the FSM
    // is not in HELD also covers "clear on PRESS".
    always_comb begin
        rpt_inc    = rpt_cnt_q + 1'b1;
        rpt_limit  = rpt_seen_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
        rpt_fire   = (state_q == ST_HELD) && !accept && (rpt_inc == rpt_limit);
        rpt_cnt_d  = rpt_cnt_q;
        rpt_seen_d = rpt_seen_q;
        if (state_q != ST_HELD || accept) begin
            rpt_cnt_d  = '0;
            rpt_seen_d = 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt_d  = '0;
            rpt_seen_d = 1'b1;
        end else begin
            rpt_cnt_d  = rpt_inc;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rpt_cnt_q  <= '0;
            rpt_seen_q <= 1'b0;
        end else begin
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_seen_q <= rpt_seen_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    keycode_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk_i     (clk_clk),
        .rst_i     (reset_reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_evt),
        .rd_en_i   (evt_ready),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .wr_drop_o (wr_drop)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) ovf_q <= 1'b0;
        else if (wr_drop) ovf_q <= 1'b1;
    end

    assign head      = evt_t'(fifo_rd_data);
    assign evt_valid = !fifo_empty;
    assign evt_type  = fifo_empty ? 2'b00 : head.etype;
    assign evt_code  = fifo_empty ? 8'h00 : head.code;
    assign held_code = held_q;
    assign dir_held  = wasd_decode(held_q);
    assign overflow  = ovf_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_keycode_event_ctrl.sv
module tb_keycode_event_ctrl;

    localparam int unsigned S     = 4;
    localparam int unsigned RD    = 20;
    localparam int unsigned RP    = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] kc = 8'h00;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [7:0] evt_code;
    logic [7:0] held_code;
    logic [3:0] dir_held;
    logic [2:0] fifo_count;
    logic       overflow;

    keycode_event_ctrl #(
        .STABLE_CYCLES (S),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .keycode     (kc),
        .evt_valid   (evt_valid),
        .evt_ready   (ready),
        .evt_type    (evt_type),
        .evt_code    (evt_code),
        .held_code   (held_code),
        .dir_held    (dir_held),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          cyc   = 0;

    // Reference model: held key from "last S samples identical", events as a queue.
    logic [7:0] m_held   = 8'h00;
    logic [7:0] hist[$];
    logic [9:0] mq[$];
    logic       m_ovf    = 1'b0;
    bit         m_pend   = 1'b0;
    int         next_rpt = -1;

    function automatic logic [3:0] exp_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 4'b1000;
            8'h04:   return 4'b0100;
            8'h16:   return 4'b0010;
            8'h07:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [9:0] exp_head();
        if (mq.size() > 0) return mq[0];
        return 10'h000;
    endfunction

    task automatic model_edge();
        bit         wr;
        logic [9:0] wv;
        bit         pop;
        bit         stable;
        int         sz;
        logic [7:0] old;
        if (rst) begin
            m_held = 8'h00; hist.delete(); mq.delete();
            m_ovf = 1'b0; m_pend = 1'b0; next_rpt = -1;
            cyc++;
            return;
        end
        wr = 0; wv = '0;
        pop = (mq.size() > 0) && ready;
        stable = (hist.size() == S);
        foreach (hist[i]) if (hist[i] != hist[0]) stable = 0;
        if (m_pend) begin
            wr = 1; wv = {2'b01, m_held}; m_pend = 0; next_rpt = cyc + RD;
        end else if (stable && hist[0] != m_held) begin
            old = m_held; m_held = hist[0]; next_rpt = -1; wr = 1;
            if (old == 8'h00) begin
                wv = {2'b01, m_held}; next_rpt = cyc + RD;
            end else begin
                wv = {2'b10, old};
                if (m_held != 8'h00) m_pend = 1;
            end
        end
`ifdef KEYCODE_REPEAT_EN
        else if (m_held != 8'h00 && cyc == next_rpt) begin
            wr = 1; wv = {2'b11, m_held}; next_rpt = cyc + RP;
        end
`endif
        sz = mq.size();
        if (pop) void'(mq.pop_front());
        if (wr) begin
            if (sz < DEPTH || pop) mq.push_back(wv);
            else m_ovf = 1'b1;
        end
        hist.push_back(kc);
        if (hist.size() > S) void'(hist.pop_front());
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic hold(input logic [7:0] k, input int n);
        kc = k;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; kc = 8'h00; ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (held_code !== 8'h00) begin bad++; $display("FAIL reset_held: got %h want 00", held_code); end
        total++; if (dir_held !== 4'b0000) begin bad++; $display("FAIL reset_dir: got %b want 0000", dir_held); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        total++; if ({evt_type, evt_code} !== 10'h000) begin bad++; $display("FAIL reset_head: got %h want 000", {evt_type, evt_code}); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_press();
        do_reset();
        kc = 8'h1A;
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if (held_code !== ((i >= 5) ? 8'h1A : 8'h00)) begin
                bad++; $display("FAIL press_latency[%0d]: got %h want %h", i, held_code, (i >= 5) ? 8'h1A : 8'h00);
            end
            if (i == 5) begin
                total++; if (dir_held !== 4'b1000) begin bad++; $display("FAIL press_dir: got %b want 1000", dir_held); end
                total++; if ({evt_valid, evt_type, evt_code} !== {1'b1, 2'b01, 8'h1A}) begin
                    bad++; $display("FAIL press_evt: got %b/%b/%h want 1/01/1a", evt_valid, evt_type, evt_code);
                end
            end
        end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL press_count: got %0d want 1", fifo_count); end
        ready = 1'b1; step(); ready = 1'b0;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL press_drain: got %b want 0", evt_valid); end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(8'h00, 6);
        kc = 8'h04;
        for (int i = 0; i < 3; i++) step();
        kc = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (held_code !== 8'h00 || fifo_count !== 3'd0) begin
                bad++; $display("FAIL glitch: got held=%h count=%0d want 00/0", held_code, fifo_count);
            end
        end
    endtask

    task automatic test_change();
        int seen;
        do_reset();
        hold(8'h1A, 8);
        ready = 1'b1; step(); ready = 1'b0;
        kc = 8'h07;
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 5) begin
                total++; if ({evt_type, evt_code} !== {2'b10, 8'h1A} || fifo_count !== 3'd1) begin
                    bad++; $display("FAIL change_release: got %b/%h cnt=%0d want 10/1a cnt=1", evt_type, evt_code, fifo_count);
                end
                total++; if (dir_held !== 4'b0001) begin bad++; $display("FAIL change_dir: got %b want 0001", dir_held); end
            end
            if (i == 6) begin
                total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL change_press_cnt: got %0d want 2", fifo_count); end
            end
        end
        ready = 1'b1; step();
        total++; if ({evt_type, evt_code} !== {2'b01, 8'h07}) begin
            bad++; $display("FAIL change_press: got %b/%h want 01/07", evt_type, evt_code);
        end
        step(); ready = 1'b0;
    endtask

    task automatic test_repeat();
        int press_at, rel_at;
        int rpt[$];
        do_reset();
        ready = 1'b1; kc = 8'h2C;
        press_at = -1; rel_at = -1;
        for (int i = 1; i <= 70; i++) begin
            if (i == 51) kc = 8'h00;
            step();
            total++; if ({evt_valid, evt_type, evt_code} !== {mq.size() > 0, exp_head()}) begin
                bad++; $display("FAIL repeat_head[%0d]: got %b/%b/%h want %b/%h", i, evt_valid, evt_type, evt_code, mq.size() > 0, exp_head());
            end
            if (evt_valid) begin
                if (evt_type == 2'b01) press_at = i;
                else if (evt_type == 2'b11) rpt.push_back(i - press_at);
                else if (evt_type == 2'b10) rel_at = i;
            end
        end
        total++; if (press_at != 5) begin bad++; $display("FAIL repeat_press_at: got %0d want 5", press_at); end
        total++; if (rel_at != 55) begin bad++; $display("FAIL repeat_release_at: got %0d want 55", rel_at); end
`ifdef KEYCODE_REPEAT_EN
        total++; if (rpt.size() != 4) begin bad++; $display("FAIL repeat_count: got %0d want 4", rpt.size()); end
        foreach (rpt[k]) begin
            total++; if (rpt[k] != 20 + 8 * k) begin bad++; $display("FAIL repeat_offset[%0d]: got %0d want %0d", k, rpt[k], 20 + 8 * k); end
        end
`else
        total++; if (rpt.size() != 0) begin bad++; $display("FAIL repeat_count: got %0d want 0", rpt.size()); end
`endif
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [9:0] want [4];
        want = '{{2'b01, 8'h1A}, {2'b10, 8'h1A}, {2'b01, 8'h07}, {2'b10, 8'h07}};
        do_reset();
        hold(8'h1A, 7); hold(8'h07, 7); hold(8'h00, 7); hold(8'h04, 7); hold(8'h00, 7);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if ({evt_type, evt_code} !== want[i]) begin
                bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, {evt_type, evt_code}, want[i]);
            end
            step();
        end
        total++; if (fifo_count !== 3'd0 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_after: got cnt=%0d ovf=%b want 0/1", fifo_count, overflow);
        end
        ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [9:0] want [4];
        want = '{{2'b10, 8'h1A}, {2'b01, 8'h04}, {2'b10, 8'h04}, {2'b01, 8'h16}};
        do_reset();
        hold(8'h1A, 7); hold(8'h00, 7); hold(8'h04, 7); hold(8'h00, 7);
        kc = 8'h16;
        for (int i = 0; i < 4; i++) step();
        ready = 1'b1; step(); ready = 1'b0;
        total++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL fullpop: got cnt=%0d ovf=%b want 4/0", fifo_count, overflow);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if ({evt_type, evt_code} !== want[i]) begin
                bad++; $display("FAIL fullpop_order[%0d]: got %h want %h", i, {evt_type, evt_code}, want[i]);
            end
            step();
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold(8'h1A, 7); hold(8'h00, 7); hold(8'h07, 7);
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL rstmid_pre: got %0d want 3", fifo_count); end
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({evt_valid, held_code, overflow} !== 10'h000) begin
            bad++; $display("FAIL rstmid: got valid=%b held=%h ovf=%b want 0/00/0", evt_valid, held_code, overflow);
        end
        kc = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid_norelease: got %0d want 0", fifo_count); end
        end
    endtask

    task automatic test_random();
        logic [7:0] keys [7];
        int dur;
        keys = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h28};
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            kc = keys[$urandom_range(6)];
            dur = ($urandom_range(3) == 0) ? $urandom_range(40, 20) : $urandom_range(12, 1);
            for (int i = 0; i < dur; i++) begin
                ready = ($urandom_range(9) < 6);
                step();
                total++; if (held_code !== m_held || dir_held !== exp_dir(m_held)) begin
                    bad++; $display("FAIL rand_held: got %h/%b want %h/%b", held_code, dir_held, m_held, exp_dir(m_held));
                end
                total++; if (fifo_count !== 3'(mq.size()) || evt_valid !== (mq.size() > 0)) begin
                    bad++; $display("FAIL rand_count: got %0d/%b want %0d", fifo_count, evt_valid, mq.size());
                end
                total++; if ({evt_type, evt_code} !== exp_head()) begin
                    bad++; $display("FAIL rand_head: got %h want %h", {evt_type, evt_code}, exp_head());
                end
                total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_ovf: got %b want %b", overflow, m_ovf); end
            end
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_change();
        test_repeat();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keycode_event_ctrl.md
Name: keycode_event_ctrl

Overview:
- Consumes the 8-bit USB HID keycode driven by the SoC keycode PIO, on the same clock as the SoC.
- Filters keycode glitches and tracks the held key.
- Converts press/release/auto-repeat into a queued event stream (valid/ready) for the game logic.
- Also exports WASD direction levels for direct movement control.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required to accept a new keycode (legal range >=2)
REPEAT_DELAY, 20, cycles from PRESS write to first REPEAT
REPEAT_PERIOD, 8, cycles between subsequent REPEATs
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
keycode  in  8  raw HID keycode from SoC PIO; 0x00 = no key
evt_valid  out  1  event available at head of queue
evt_ready  in  1  consumer accepts head event when evt_valid && evt_ready
evt_type  out  2  01 PRESS, 10 RELEASE, 11 REPEAT; 00 never emitted
evt_code  out  8  keycode of head event
held_code  out  8  currently accepted (filtered) keycode
dir_held  out  4  {W,A,S,D} held levels, decoded from held_code
fifo_count  out  clog2(FIFO_DEPTH)+1  entries queued
overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset state: all outputs 0; queue empty; candidate, counters and FSM cleared (FSM = IDLE). Reset mid-stream discards all queued events and does not emit RELEASE for the held key.
- Filter:
  - cand register plus stability counter.
  - When keycode != cand: load cand and restart the count at 1.
  - When the count reaches STABLE_CYCLES with cand != held_code: held_code <= cand on the next edge (the "accept"). Total latency from a keycode change to held_code update is STABLE_CYCLES+1 cycles.
  - Glitches shorter than STABLE_CYCLES never change held_code.
- dir_held follows held_code combinationally: W=0x1A, A=0x04, S=0x16, D=0x07. Any other code gives 0000.
- FSM states:
  - IDLE: held_code==0.
  - HELD: nonzero key held.
  - EMIT_PRESS: one-cycle state that writes the deferred PRESS.
- FSM transitions on accept (old -> new):
  - old==0, new!=0: write PRESS(new) in the accept cycle; go to HELD.
  - old!=0, new==0: write RELEASE(old); go to IDLE.
  - old!=0, new!=0: write RELEASE(old) in the accept cycle, then go to EMIT_PRESS, write PRESS(new) the next cycle, then go to HELD.
  - STABLE_CYCLES>=2 guarantees no second accept can occur during EMIT_PRESS.
- Repeat timer:
  - Clears on every PRESS write.
  - In HELD it counts each cycle. REPEAT(held_code) is written when the count hits REPEAT_DELAY; thereafter it is written every REPEAT_PERIOD cycles.
  - The timer stops and clears on leaving HELD.
- Queue: synchronous FIFO, first-word-fall-through; evt_valid = !empty.
  - Pop happens when evt_valid && evt_ready.
  - A write while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set until reset. Other state proceeds unaffected; held_code and dir_held never stall.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop on an empty queue: the written entry becomes head next cycle (no bypass).
- At most one write per cycle by construction.

Optional Feature:
- KEYCODE_REPEAT_EN
  - Defined: the repeat timer and REPEAT events are generated as described above.
  - Undefined: no repeat logic is synthesized, evt_type 11 is never produced, and REPEAT_DELAY/REPEAT_PERIOD are ignored. All other behaviour is identical.

Decomposition:
- Package keycode_pkg contains:
  - HID constants KC_W, KC_A, KC_S, KC_D, KC_SPACE=0x2C, KC_ENTER=0x28.
  - evt_type_t enum {EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_REPEAT=2'b11}.
  - 10-bit packed event struct {type, code}.
  - FSM state enum.
- Sub-module keycode_evt_fifo: generic sync FIFO (DEPTH, WIDTH=10) with count and full/empty; the top level holds the filter, FSM, repeat timer and WASD decode.

Test Plan:
- Hold keycode=0x1A for 10 cycles after reset -> held_code=0x1A at cycle 5; dir_held=1000; one event PRESS/0x1A; evt_ready=1 drains it.
- Drive 0x04 for 3 cycles inside a 0x00 stream (glitch) -> no held_code change, no events, fifo_count stays 0.
- Change 0x1A -> 0x07 directly -> RELEASE/0x1A then PRESS/0x07 on consecutive cycles; dir_held 1000 -> 0001.
- With KEYCODE_REPEAT_EN, hold 0x2C for 50 cycles with evt_ready=1 -> PRESS, then REPEATs at +20, +28, +36, +44 cycles after PRESS; none after release; RELEASE/0x2C emitted on release.
- evt_ready=0, generate 6 events (DEPTH 4) -> fifo_count=4, overflow=1, and the first four events drain in order. Write+pop in the same cycle when full -> no drop.
- Assert reset_reset with 3 queued events while a key is held -> next cycle evt_valid=0, held_code=0, overflow=0, and no RELEASE is emitted.
